elastic_buffer: RTL and testbench
=================================

ELASTIC_BUFFER -- requirements
Module: elastic_buffer

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning payload width in bits (W >= 1).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning number of storage entries (DEPTH >= 2, any integer, not restricted to powers of two).
REQ-003 The block SHALL have parameter FALLTHROUGH, default 0, meaning 0 = registered output, 1 = zero-latency bypass when empty.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous discard of all stored entries.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream beat valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the buffer accepts a beat.
REQ-009 The block SHALL have port in_data, input, W bits: upstream payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit: downstream beat valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts a beat.
REQ-012 The block SHALL have port out_data, output, W bits: downstream payload.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH+1) bits: number of stored entries.
REQ-014 The block SHALL have ports full and empty, outputs, 1 bit each: full = (count == DEPTH), empty = (count == 0).

Function
REQ-015 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL equal !full && !flush and SHALL depend only on registered state and flush, with no combinational path from out_ready or in_valid.
REQ-017 Storage SHALL be a circular buffer of DEPTH entries with write and read pointers that wrap from DEPTH-1 to 0.
REQ-018 With FALLTHROUGH=0: out_valid = !empty && !flush, out_data = entry at the read pointer, and push-to-out_valid latency SHALL be 1 cycle.
REQ-019 With FALLTHROUGH=1 and empty: out_valid = in_valid && !flush and out_data = in_data (0-cycle latency).
REQ-020 With FALLTHROUGH=1 and empty: a beat pushed and popped in the same cycle SHALL NOT be stored, and count SHALL stay 0.
REQ-021 With FALLTHROUGH=1 and not empty: the block SHALL behave as in REQ-018.
REQ-022 Simultaneous push and pop when not full SHALL leave count unchanged and advance both pointers.
REQ-023 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle; the freed slot SHALL be offered on the next cycle.
REQ-024 count SHALL be updated each cycle as +1 on push only, -1 on pop only, and unchanged otherwise, and SHALL never exceed DEPTH or go below 0.
REQ-025 While out_valid && !out_ready, out_data SHALL remain stable and out_valid SHALL remain 1 until the pop (in FALLTHROUGH bypass mode this holds only if the upstream holds in_valid and in_data).
REQ-026 Beats SHALL leave in exactly the order they were accepted, with no loss and no duplication.
REQ-027 flush high SHALL force in_ready=0 and out_valid=0 in that cycle, so no push or pop occurs.
REQ-028 On the next rising edge after flush, count and both pointers SHALL be set to 0.
REQ-029 Flush SHALL take priority over all other events.

Reset
REQ-030 On rst_n low, count, the write pointer and the read pointer SHALL clear to 0 immediately, regardless of clk.
REQ-031 During reset, outputs SHALL be: out_valid=0 (FALLTHROUGH=0) or in_valid (FALLTHROUGH=1), in_ready=1, empty=1, full=0.
REQ-032 Storage contents SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-033 Reset asserted mid-transfer SHALL discard all stored beats, and no stored beat SHALL appear after reset is released.

Verification
REQ-034 Directed test, DEPTH=4, FALLTHROUGH=0, out_ready=0: push 0x11,0x22,0x33,0x44 -> count 1..4, full=1 after the 4th push, in_ready=0; set out_ready=1 -> the beats are output in order 0x11..0x44, with count reaching 0 four cycles later.
REQ-035 Directed test, FALLTHROUGH=1, empty, in_valid=1, in_data=0xA5, out_ready=1 -> out_valid=1 and out_data=0xA5 in the same cycle, with count staying 0.
REQ-036 Directed test, DEPTH=3: 10 continuous beats 0..9 with out_ready=1 throughout -> one pop per cycle after the first, count steady at 1 (FALLTHROUGH=0), and pointers wrap past 2 with correct order.
REQ-037 Directed test, full DEPTH=2 with push and pop requested in the same cycle -> pop occurs, push is refused (in_ready=0), and the push is accepted next cycle.
REQ-038 Directed test: flush with count=3 -> out_valid=0 and in_ready=0 that cycle, then count=0, empty=1 next cycle, and the next output beat is the first beat pushed after the flush.
REQ-039 Directed test: rst_n low mid-stream with count=2 -> count=0 asynchronously, and no old beat appears after release.

Source files
------------

// File: rtl/elastic_buffer.sv
// rtl/elastic_buffer.sv - ready/valid elastic FIFO with optional zero-latency bypass
module elastic_buffer #(
    parameter int W           = 32,
    parameter int DEPTH       = 2,
    parameter int FALLTHROUGH = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam bit FT = (FALLTHROUGH != 0);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_store;
    logic w_take;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign count    = r_count;
    assign empty    = (r_count == '0);
    assign full     = (r_count == CW'(DEPTH));
    assign in_ready = !full && !flush;

    // When empty in bypass mode the upstream beat is presented directly downstream.
    assign w_bypass  = FT && empty;
    assign out_valid = !flush && (w_bypass ? in_valid : !empty);
    assign out_data  = w_bypass ? in_data : r_mem[r_rptr];

    assign w_push  = in_valid && in_ready;
    assign w_pop   = out_valid && out_ready;
    // A bypassed beat consumed in the same cycle never touches storage.
    assign w_store = w_push && !(w_bypass && w_pop);
    assign w_take  = w_pop && !w_bypass;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_wptr <= ptr_next(r_wptr);
            end
            if (w_take) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({w_store, w_take})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_elastic_buffer.sv
// tb/tb_elastic_buffer.sv - directed vectors plus randomized queue-model check of elastic_buffer
module tb_elastic_buffer;

    logic       clk;
    logic       rst_n;
    logic [2:0] flush;
    logic [2:0] in_valid;
    logic [2:0] in_ready;
    logic [2:0] out_valid;
    logic [2:0] out_ready;
    logic [2:0] full;
    logic [2:0] empty;
    logic [7:0] in_data  [3];
    logic [7:0] out_data [3];
    logic [2:0] count    [3];
    logic       rnd_on;

    int n_cmp = 0;
    int n_err = 0;

    function automatic int dep(input int g);
        return (g == 0) ? 4 : (g == 1) ? 3 : 2;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Instance 0: DEPTH 4 registered, 1: DEPTH 3 registered, 2: DEPTH 2 bypass
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D  = (g == 0) ? 4 : (g == 1) ? 3 : 2;
        localparam int FT = (g == 2) ? 1 : 0;
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] cnt;
        logic [7:0]    q[$];

        elastic_buffer #(.W(8), .DEPTH(D), .FALLTHROUGH(FT)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .count     (cnt),
            .full      (full[g]),
            .empty     (empty[g])
        );
        assign count[g] = 3'(cnt);

        // Reference: a queue of accepted beats, head is the next beat out.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q.delete();
            end else if (flush[g]) begin
                q.delete();
            end else begin
                bit mv, pop, push;
                mv   = (q.size() > 0) || (FT == 1 && in_valid[g]);
                pop  = mv && out_ready[g];
                push = in_valid[g] && (q.size() < D);
                if (!(pop && q.size() == 0)) begin
                    if (pop) void'(q.pop_front());
                    if (push) q.push_back(in_data[g]);
                end
            end
        end

        always @(negedge clk) begin
            #3;
            if (rnd_on && rst_n) begin
                bit ev;
                ev = !flush[g] && ((q.size() > 0) || (FT == 1 && in_valid[g]));
                chk($sformatf("rnd%0d in_ready", g), in_ready[g], !flush[g] && (q.size() < D));
                chk($sformatf("rnd%0d out_valid", g), out_valid[g], ev);
                if (ev) chk($sformatf("rnd%0d out_data", g), out_data[g], (q.size() > 0) ? q[0] : in_data[g]);
                chk($sformatf("rnd%0d count", g), count[g], q.size());
                chk($sformatf("rnd%0d full", g), full[g], q.size() == D);
                chk($sformatf("rnd%0d empty", g), empty[g], q.size() == 0);
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step(input int g, input bit iv, input logic [7:0] d, input bit ordy, input bit fl,
                        input bit eir, input bit eov, input logic [7:0] eod, input int ecnt, input string tag);
        @(negedge clk);
        in_valid[g]  = iv;
        in_data[g]   = d;
        out_ready[g] = ordy;
        flush[g]     = fl;
        #2;
        chk({tag, " in_ready"}, in_ready[g], eir);
        chk({tag, " out_valid"}, out_valid[g], eov);
        if (eov) chk({tag, " out_data"}, out_data[g], eod);
        chk({tag, " count"}, count[g], ecnt);
        chk({tag, " full"}, full[g], ecnt == dep(g));
        chk({tag, " empty"}, empty[g], ecnt == 0);
    endtask

    typedef struct {
        bit         iv;
        logic [7:0] d;
        bit         ordy;
        bit         fl;
        bit         eir;
        bit         eov;
        logic [7:0] eod;
        int         ecnt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        rst_n     = 1'b0;
        rnd_on    = 1'b0;
        flush     = '0;
        in_valid  = '0;
        out_ready = '0;
        for (int i = 0; i < 3; i++) in_data[i] = '0;

        // Fill, hold, drain in order; then flush with three stored beats.
        tbl[0]  = '{1, 8'h11, 0, 0, 1, 0, 8'h00, 0};
        tbl[1]  = '{1, 8'h22, 0, 0, 1, 1, 8'h11, 1};
        tbl[2]  = '{1, 8'h33, 0, 0, 1, 1, 8'h11, 2};
        tbl[3]  = '{1, 8'h44, 0, 0, 1, 1, 8'h11, 3};
        tbl[4]  = '{0, 8'h00, 0, 0, 0, 1, 8'h11, 4};
        tbl[5]  = '{0, 8'h00, 1, 0, 0, 1, 8'h11, 4};
        tbl[6]  = '{0, 8'h00, 1, 0, 1, 1, 8'h22, 3};
        tbl[7]  = '{0, 8'h00, 1, 0, 1, 1, 8'h33, 2};
        tbl[8]  = '{0, 8'h00, 1, 0, 1, 1, 8'h44, 1};
        tbl[9]  = '{0, 8'h00, 0, 0, 1, 0, 8'h00, 0};
        tbl[10] = '{1, 8'h01, 0, 0, 1, 0, 8'h00, 0};
        tbl[11] = '{1, 8'h02, 0, 0, 1, 1, 8'h01, 1};
        tbl[12] = '{1, 8'h03, 0, 0, 1, 1, 8'h01, 2};
        tbl[13] = '{1, 8'h04, 1, 1, 0, 0, 8'h00, 3};
        tbl[14] = '{1, 8'h05, 0, 0, 1, 0, 8'h00, 0};
        tbl[15] = '{0, 8'h00, 1, 0, 1, 1, 8'h05, 1};
        tbl[16] = '{0, 8'h00, 0, 0, 1, 0, 8'h00, 0};

        #2;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("reset%0d out_valid", g), out_valid[g], 0);
            chk($sformatf("reset%0d in_ready", g), in_ready[g], 1);
            chk($sformatf("reset%0d empty", g), empty[g], 1);
            chk($sformatf("reset%0d full", g), full[g], 0);
            chk($sformatf("reset%0d count", g), count[g], 0);
        end
        in_valid[2] = 1'b1;
        #1 chk("reset2 out_valid follows in_valid hi", out_valid[2], 1);
        in_valid[2] = 1'b0;
        #1 chk("reset2 out_valid follows in_valid lo", out_valid[2], 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++)
            step(0, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl,
                 tbl[i].eir, tbl[i].eov, tbl[i].eod, tbl[i].ecnt, $sformatf("vec%0d", i));

        // Bypass: same-cycle pass-through, nothing stored.
        step(2, 1, 8'hA5, 1, 0, 1, 1, 8'hA5, 0, "ft pass");
        step(2, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, "ft after");

        // DEPTH 3 streaming with wrap.
        for (int k = 0; k < 10; k++)
            step(1, 1, 8'(k), 1, 0, 1, k > 0, 8'(k - 1), (k > 0) ? 1 : 0, $sformatf("stream%0d", k));
        step(1, 0, 8'h00, 1, 0, 1, 1, 8'h09, 1, "stream tail");
        step(1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, "stream idle");

        // DEPTH 2 full with simultaneous push and pop.
        step(2, 1, 8'h01, 0, 0, 1, 1, 8'h01, 0, "full s1");
        step(2, 1, 8'h02, 0, 0, 1, 1, 8'h01, 1, "full s2");
        step(2, 1, 8'h03, 1, 0, 0, 1, 8'h01, 2, "full s3");
        step(2, 1, 8'h03, 0, 0, 1, 1, 8'h02, 1, "full s4");
        step(2, 0, 8'h00, 1, 0, 0, 1, 8'h02, 2, "full s5");
        step(2, 0, 8'h00, 1, 0, 1, 1, 8'h03, 1, "full s6");
        step(2, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, "full s7");

        // Asynchronous reset mid-stream with two stored beats.
        step(0, 1, 8'hAA, 0, 0, 1, 0, 8'h00, 0, "rst a");
        step(0, 1, 8'hBB, 0, 0, 1, 1, 8'hAA, 1, "rst b");
        step(0, 0, 8'h00, 0, 0, 1, 1, 8'hAA, 2, "rst c");
        rst_n       = 1'b0;
        in_valid[2] = 1'b1;
        #1;
        chk("rst async count", count[0], 0);
        chk("rst async empty", empty[0], 1);
        chk("rst async in_ready", in_ready[0], 1);
        chk("rst async out_valid", out_valid[0], 0);
        chk("rst ft out_valid", out_valid[2], 1);
        in_valid[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, "post rst 1");
        step(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, "post rst 2");
        step(0, 1, 8'hCC, 1, 0, 1, 0, 8'h00, 0, "post rst push");
        step(0, 0, 8'h00, 1, 0, 1, 1, 8'hCC, 1, "post rst out");
        step(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, "post rst idle");

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        rnd_on = 1'b1;
        for (int p = 0; p < 4; p++) begin
            int pv, pr;
            pv = (p == 2) ? 30 : (p == 3) ? 60 : 90;
            pr = (p == 1) ? 30 : (p == 3) ? 60 : 90;
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                for (int g = 0; g < 3; g++) begin
                    in_valid[g]  = ($urandom_range(0, 99) < pv);
                    out_ready[g] = ($urandom_range(0, 99) < pr);
                    flush[g]     = ($urandom_range(0, 99) < 2);
                    in_data[g]   = 8'($urandom);
                end
            end
        end
        #5;
        rnd_on = 1'b0;
        #10;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
